// File: rtl/rv_wb_arb_if.sv
// Writeback arbiter bus bundle: ALU result channel, LSU load-return channel,
// register-file write port and pending-destination mask.
`ifndef MXLEN
`define MXLEN 32
`endif

interface rv_wb_arb_if #(
    parameter int XLEN = `MXLEN
);
    logic            alu_vld_i;
    logic [4:0]      alu_rd_i;
    logic [XLEN-1:0] alu_data_i;
    logic            lsu_vld_i;
    logic            lsu_rdy_o;
    logic [4:0]      lsu_rd_i;
    logic [2:0]      lsu_funct3_i;
    logic [1:0]      lsu_addr_i;
    logic [31:0]     lsu_rdata_i;
    logic [4:0]      wr_reg_o;
    logic [XLEN-1:0] wr_data_o;
    logic            wr_en_o;
    logic [31:0]     pending_o;

    modport master (
        output alu_vld_i, alu_rd_i, alu_data_i,
        output lsu_vld_i, lsu_rd_i, lsu_funct3_i, lsu_addr_i, lsu_rdata_i,
        input  lsu_rdy_o, wr_reg_o, wr_data_o, wr_en_o, pending_o
    );

    modport slave (
        input  alu_vld_i, alu_rd_i, alu_data_i,
        input  lsu_vld_i, lsu_rd_i, lsu_funct3_i, lsu_addr_i, lsu_rdata_i,
        output lsu_rdy_o, wr_reg_o, wr_data_o, wr_en_o, pending_o
    );
endinterface

// File: rtl/rv_wb_arb.sv
// Writeback arbiter: ALU results take the RF port first, buffered loads fill idle slots.
// Optional RV_WB_PERF_EN adds a saturating count of cycles where loads were deferred.
module rv_wb_arb #(
    parameter int XLEN     = `MXLEN,
    parameter int LQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef RV_WB_PERF_EN
    output logic [31:0] lq_defer_cnt_o,
`endif
    rv_wb_arb_if.slave  bus
);
    localparam int          AW       = $clog2(LQ_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(LQ_DEPTH);

    function automatic logic [XLEN-1:0] load_extract(
        input logic [31:0] word,
        input logic [2:0]  funct3,
        input logic [1:0]  addr
    );
        logic [7:0]      byte_v;
        logic [15:0]     half_v;
        logic [XLEN-1:0] res_v;
        byte_v = word[{addr, 3'b000} +: 8];
        half_v = word[{addr[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  res_v = XLEN'($signed(byte_v));
            3'b001:  res_v = XLEN'($signed(half_v));
            3'b100:  res_v = XLEN'(byte_v);
            3'b101:  res_v = XLEN'(half_v);
            default: res_v = XLEN'($signed(word));
        endcase
        return res_v;
    endfunction

    logic [4:0]          q_rd_r     [LQ_DEPTH];
    logic [2:0]          q_funct3_r [LQ_DEPTH];
    logic [1:0]          q_addr_r   [LQ_DEPTH];
    logic [31:0]         q_data_r   [LQ_DEPTH];
    // live = occupied and not killed by a younger ALU write
    logic [LQ_DEPTH-1:0] q_live_r;
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [AW:0]         count_r;

    logic                wr_en_r;
    logic [4:0]          wr_reg_r;
    logic [XLEN-1:0]     wr_data_r;

    logic                alu_win_s;
    logic                q_empty_s;
    logic                pop_s;
    logic                push_s;
    logic                head_live_s;
    logic                lsu_rdy_s;
    logic [31:0]         pending_s;

    // Slot arbitration and load-accept decode
    always_comb begin
        alu_win_s   = bus.alu_vld_i && (bus.alu_rd_i != 5'd0);
        q_empty_s   = (count_r == {(AW+1){1'b0}});
        pop_s       = !alu_win_s && !q_empty_s;
        lsu_rdy_s   = !rst && (count_r != FULL_CNT);
        push_s      = bus.lsu_vld_i && lsu_rdy_s && (bus.lsu_rd_i != 5'd0);
        head_live_s = q_live_r[rd_ptr_r];
    end

    // Pending-destination mask from live queue entries
    always_comb begin
        pending_s = 32'd0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (q_live_r[i]) begin
                pending_s[q_rd_r[i]] = 1'b1;
            end else begin
                pending_s = pending_s;
            end
        end
        pending_s[0] = 1'b0;
    end

    // Queue payload; only written on push, so it needs no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_rd_r[wr_ptr_r]     <= bus.lsu_rd_i;
            q_funct3_r[wr_ptr_r] <= bus.lsu_funct3_i;
            q_addr_r[wr_ptr_r]   <= bus.lsu_addr_i;
            q_data_r[wr_ptr_r]   <= bus.lsu_rdata_i;
        end
    end

    // Queue control and registered RF write port
    always_ff @(posedge clk) begin
        if (rst) begin
            q_live_r  <= {LQ_DEPTH{1'b0}};
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {(AW+1){1'b0}};
            wr_en_r   <= 1'b0;
            wr_reg_r  <= 5'd0;
            wr_data_r <= {XLEN{1'b0}};
        end else begin
            // Kill older entries first; a same-cycle push below is younger and survives
            for (int i = 0; i < LQ_DEPTH; i++) begin
                if (alu_win_s && (q_rd_r[i] == bus.alu_rd_i)) begin
                    q_live_r[i] <= 1'b0;
                end
            end
            if (pop_s) begin
                q_live_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r           <= rd_ptr_r + AW'(1);
            end
            if (push_s) begin
                q_live_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r           <= wr_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase

            if (alu_win_s) begin
                wr_en_r   <= 1'b1;
                wr_reg_r  <= bus.alu_rd_i;
                wr_data_r <= bus.alu_data_i;
            end else if (pop_s && head_live_s) begin
                wr_en_r   <= 1'b1;
                wr_reg_r  <= q_rd_r[rd_ptr_r];
                wr_data_r <= load_extract(q_data_r[rd_ptr_r], q_funct3_r[rd_ptr_r],
                                          q_addr_r[rd_ptr_r]);
            end else begin
                wr_en_r   <= 1'b0;
            end
        end
    end

    assign bus.lsu_rdy_o = lsu_rdy_s;
    assign bus.pending_o = pending_s;
    assign bus.wr_en_o   = wr_en_r;
    assign bus.wr_reg_o  = wr_reg_r;
    assign bus.wr_data_o = wr_data_r;

`ifdef RV_WB_PERF_EN
    logic [31:0] defer_cnt_r;

    // Saturating count of cycles a waiting load lost the slot to the ALU
    always_ff @(posedge clk) begin
        if (rst) begin
            defer_cnt_r <= 32'd0;
        end else if (alu_win_s && !q_empty_s && (defer_cnt_r != 32'hFFFF_FFFF)) begin
            defer_cnt_r <= defer_cnt_r + 32'd1;
        end else begin
            defer_cnt_r <= defer_cnt_r;
        end
    end

    assign lq_defer_cnt_o = defer_cnt_r;
`endif
endmodule
